multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the single-issue RV32 core. Fetches one instruction per pass,

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer: state encoding,
// special instruction words and the default reset vector.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } ctrl_state_t;

    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32 core. Each instruction
// passes through FETCH -> DECODE -> EXECUTE -> WRITEBACK. The latched
// instruction feeds the external decoder, alu_en paces the ALU and rf_wen
// is limited to the writeback cycle. The core halts on ebreak, on an illegal
// instruction, or when instruction memory fails to answer in time.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned FETCH_TMO = 255,
    parameter int unsigned TMO_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    input  logic        dec_wen,
    input  logic        dec_illegal,
    output logic        alu_en,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        halt,
    output logic        trap
);

    // Last FETCH cycle count before the fetch is declared dead.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);

    ctrl_state_t      state_q;
    ctrl_state_t      state_d;
    logic [31:0]      pc_q;
    logic [31:0]      inst_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             halt_q;
    logic             trap_q;

    logic             load_inst;
    logic             adv_pc;
    logic             set_halt;
    logic             set_trap;

    // Next-state selection and Moore strobes; rf_wen additionally follows dec_wen.
    always_comb begin
        state_d   = state_q;
        load_inst = 1'b0;
        adv_pc    = 1'b0;
        set_halt  = 1'b0;
        set_trap  = 1'b0;
        imem_req  = 1'b0;
        alu_en    = 1'b0;
        rf_wen    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                // A response arriving on the final allowed cycle still wins.
                if (imem_rvalid) begin
                    load_inst = 1'b1;
                    state_d   = DECODE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    set_halt = 1'b1;
                    set_trap = 1'b1;
                    state_d  = HALT;
                end
            end
            DECODE: begin
                // ebreak is a clean stop even if the decoder also flags it illegal.
                if (inst_q == INST_EBREAK) begin
                    set_halt = 1'b1;
                    state_d  = HALT;
                end else if (dec_illegal) begin
                    set_halt = 1'b1;
                    set_trap = 1'b1;
                    state_d  = HALT;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                alu_en  = 1'b1;
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                rf_wen  = dec_wen;
                adv_pc  = 1'b1;
                state_d = run ? FETCH : IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: FSM register plus the sticky halt/trap flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_halt) begin
                halt_q <= 1'b1;
            end
            if (set_trap) begin
                trap_q <= 1'b1;
            end
        end
    end

    // Program counter, instruction latch and fetch timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            inst_q    <= INST_NOP;
            tmo_cnt_q <= '0;
        end else begin
            if (adv_pc) begin
                pc_q <= pc_q + 32'd4;
            end
            if (load_inst) begin
                inst_q <= imem_rdata;
            end
            // Counter only runs while waiting in FETCH; any other cycle rearms it.
            if (state_q == FETCH && !imem_rvalid) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign halt      = halt_q;
    assign trap      = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus a randomized program
// run checked against a per-instruction behavioural model.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int FETCH_TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        dec_wen;
    logic        dec_illegal;
    logic        alu_en;
    logic        rf_wen;
    logic [31:0] pc;
    logic        halt;
    logic        trap;

    // Second instance starting near the top of the address space for the wrap case.
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_inst;
    logic        w_alu_en;
    logic        w_rf_wen;
    logic [31:0] w_pc;
    logic        w_halt;
    logic        w_trap;

    logic [4:0]  strobes;
    assign strobes = {imem_req, alu_en, rf_wen, halt, trap};

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;

    multicycle_ctrl #(.RESET_PC(32'h8000_0000), .FETCH_TMO(FETCH_TMO), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .inst(inst), .dec_wen(dec_wen),
        .dec_illegal(dec_illegal), .alu_en(alu_en), .rf_wen(rf_wen),
        .pc(pc), .halt(halt), .trap(trap)
    );

    multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC), .FETCH_TMO(FETCH_TMO), .TMO_W(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .inst(w_inst), .dec_wen(dec_wen),
        .dec_illegal(dec_illegal), .alu_en(w_alu_en), .rf_wen(w_rf_wen),
        .pc(w_pc), .halt(w_halt), .trap(w_trap)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        run         = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        dec_wen     = 1'b0;
        dec_illegal = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        exp_pc   = 32'h8000_0000;
        exp_inst = INST_NOP;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++;
            if (strobes !== 5'b00000) begin
                failures++;
                $display("FAIL reset_strobes cyc=%0d got=%b exp=00000", c, strobes);
            end
            checks++;
            if (pc !== 32'h8000_0000 || imem_addr !== 32'h8000_0000) begin
                failures++;
                $display("FAIL reset_pc cyc=%0d got=%h/%h exp=80000000", c, pc, imem_addr);
            end
            checks++;
            if (inst !== INST_NOP) begin
                failures++;
                $display("FAIL reset_inst cyc=%0d got=%h exp=%h", c, inst, INST_NOP);
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        // cycle 0: IDLE with run raised
        run = 1'b1;
        #2;
        checks++;
        if (strobes !== 5'b00000) begin
            failures++;
            $display("FAIL single_c0 got=%b exp=00000", strobes);
        end
        next_cycle();
        // cycle 1: zero-wait fetch
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0010_7093;
        #2;
        checks++;
        if (strobes !== 5'b10000 || imem_addr !== 32'h8000_0000) begin
            failures++;
            $display("FAIL single_c1 got=%b/%h exp=10000/80000000", strobes, imem_addr);
        end
        next_cycle();
        // cycle 2: decode
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        dec_wen     = 1'b1;
        #2;
        checks++;
        if (strobes !== 5'b00000 || inst !== 32'h0010_7093) begin
            failures++;
            $display("FAIL single_c2 got=%b/%h exp=00000/00107093", strobes, inst);
        end
        next_cycle();
        #2;
        checks++;
        if (strobes !== 5'b01000) begin
            failures++;
            $display("FAIL single_c3_alu got=%b exp=01000", strobes);
        end
        next_cycle();
        #2;
        checks++;
        if (strobes !== 5'b00100 || pc !== 32'h8000_0000) begin
            failures++;
            $display("FAIL single_c4_wb got=%b/%h exp=00100/80000000", strobes, pc);
        end
        next_cycle();
        // cycles 5..8: fetch with three wait cycles
        for (int k = 0; k < 4; k++) begin
            imem_rvalid = (k == 3);
            imem_rdata  = (k == 3) ? 32'h0020_8133 : $urandom;
            #2;
            checks++;
            if (strobes !== 5'b10000 || imem_addr !== 32'h8000_0004 || inst !== 32'h0010_7093) begin
                failures++;
                $display("FAIL wait_fetch k=%0d got=%b/%h/%h exp=10000/80000004/00107093",
                         k, strobes, imem_addr, inst);
            end
            if (k == 0) begin
                checks++;
                if (w_pc !== 32'h0000_0000) begin
                    failures++;
                    $display("FAIL pc_wrap got=%h exp=00000000", w_pc);
                end
            end
            next_cycle();
        end
        imem_rvalid = 1'b0;
        #2;
        checks++;
        if (strobes !== 5'b00000 || inst !== 32'h0020_8133) begin
            failures++;
            $display("FAIL wait_decode got=%b/%h exp=00000/00208133", strobes, inst);
        end
        next_cycle();
        // run dropped during EXECUTE must not abort the instruction
        run = 1'b0;
        #2;
        checks++;
        if (strobes !== 5'b01000) begin
            failures++;
            $display("FAIL wait_exec got=%b exp=01000", strobes);
        end
        next_cycle();
        #2;
        checks++;
        if (strobes !== 5'b00100) begin
            failures++;
            $display("FAIL wait_wb got=%b exp=00100", strobes);
        end
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++;
            if (strobes !== 5'b00000 || pc !== 32'h8000_0008) begin
                failures++;
                $display("FAIL park_idle cyc=%0d got=%b/%h exp=00000/80000008", c, strobes, pc);
            end
            next_cycle();
        end
        // reset arriving during a fetch wait
        run = 1'b1;
        next_cycle();
        #2;
        checks++;
        if (strobes !== 5'b10000 || imem_addr !== 32'h8000_0008) begin
            failures++;
            $display("FAIL prereset_fetch got=%b/%h exp=10000/80000008", strobes, imem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (strobes !== 5'b00000 || pc !== 32'h8000_0000 || inst !== INST_NOP) begin
            failures++;
            $display("FAIL async_reset got=%b/%h/%h exp=00000/80000000/%h", strobes, pc, inst, INST_NOP);
        end
        run     = 1'b0;
        dec_wen = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_ebreak();
        apply_reset();
        run = 1'b1;
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = INST_EBREAK;
        next_cycle();
        imem_rvalid = 1'b0;
        dec_illegal = 1'($urandom_range(0, 1));
        dec_wen     = 1'b1;
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            run = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if (strobes !== 5'b00010 || pc !== 32'h8000_0000 || inst !== INST_EBREAK) begin
                failures++;
                $display("FAIL ebreak_halt cyc=%0d got=%b/%h/%h exp=00010/80000000/%h",
                         c, strobes, pc, inst, INST_EBREAK);
            end
            next_cycle();
        end
        dec_illegal = 1'b0;
        dec_wen     = 1'b0;
    endtask

    task automatic test_illegal();
        apply_reset();
        run = 1'b1;
        next_cycle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        next_cycle();
        imem_rvalid = 1'b0;
        dec_illegal = 1'b1;
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (strobes !== 5'b00011 || pc !== 32'h8000_0000) begin
                failures++;
                $display("FAIL illegal_trap cyc=%0d got=%b/%h exp=00011/80000000", c, strobes, pc);
            end
            next_cycle();
        end
        dec_illegal = 1'b0;
    endtask

    task automatic test_timeout();
        int bad_cyc;
        apply_reset();
        run = 1'b1;
        next_cycle();
        bad_cyc = -1;
        for (int k = 0; k < FETCH_TMO; k++) begin
            #2;
            if (strobes !== 5'b10000 && bad_cyc < 0) bad_cyc = k;
            next_cycle();
        end
        checks++;
        if (bad_cyc >= 0) begin
            failures++;
            $display("FAIL tmo_wait_req first_bad_cycle=%0d exp=none", bad_cyc);
        end
        #2;
        checks++;
        if (strobes !== 5'b00011 || pc !== 32'h8000_0000) begin
            failures++;
            $display("FAIL tmo_trap got=%b/%h exp=00011/80000000", strobes, pc);
        end
        next_cycle();
        // rvalid on the very last allowed cycle beats the timeout
        apply_reset();
        run = 1'b1;
        next_cycle();
        for (int k = 0; k < FETCH_TMO; k++) begin
            imem_rvalid = (k == FETCH_TMO - 1);
            imem_rdata  = 32'h0000_0513;
            next_cycle();
        end
        imem_rvalid = 1'b0;
        #2;
        checks++;
        if (strobes !== 5'b00000 || inst !== 32'h0000_0513) begin
            failures++;
            $display("FAIL tmo_rvalid_priority got=%b/%h exp=00000/00000513", strobes, inst);
        end
        next_cycle();
        #2;
        checks++;
        if (strobes !== 5'b01000) begin
            failures++;
            $display("FAIL tmo_priority_exec got=%b exp=01000", strobes);
        end
        next_cycle();
    endtask

    // Model: each instruction is (idle gap, fetch wait, word, kind, wen); the
    // expected cycle sequence and PC follow directly from those choices.
    task automatic test_random_program(input int n_instr);
        bit          in_fetch;
        int          idle_n;
        int          wait_n;
        int          kind;
        bit          wen;
        logic [31:0] word;
        logic [4:0]  exp_st;
        in_fetch = 1'b0;
        for (int i = 0; i < n_instr; i++) begin
            if (!in_fetch) begin
                idle_n = $urandom_range(0, 2);
                for (int c = 0; c <= idle_n; c++) begin
                    run = (c == idle_n);
                    #2;
                    checks++;
                    if (strobes !== 5'b00000 || pc !== exp_pc) begin
                        failures++;
                        $display("FAIL rnd_idle i=%0d got=%b/%h exp=00000/%h", i, strobes, pc, exp_pc);
                    end
                    next_cycle();
                end
            end
            wait_n = $urandom_range(0, 3);
            kind   = $urandom_range(0, 19);
            wen    = 1'($urandom_range(0, 1));
            word   = (kind == 0) ? INST_EBREAK : $urandom;
            if (kind != 0 && word == INST_EBREAK) word = word ^ 32'h1;
            for (int k = 0; k <= wait_n; k++) begin
                imem_rvalid = (k == wait_n);
                imem_rdata  = (k == wait_n) ? word : $urandom;
                #2;
                checks++;
                if (strobes !== 5'b10000 || imem_addr !== exp_pc || inst !== exp_inst) begin
                    failures++;
                    $display("FAIL rnd_fetch i=%0d k=%0d got=%b/%h/%h exp=10000/%h/%h",
                             i, k, strobes, imem_addr, inst, exp_pc, exp_inst);
                end
                next_cycle();
            end
            imem_rvalid = 1'b0;
            exp_inst    = word;
            dec_illegal = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            dec_wen     = wen;
            #2;
            checks++;
            if (strobes !== 5'b00000 || inst !== exp_inst) begin
                failures++;
                $display("FAIL rnd_decode i=%0d got=%b/%h exp=00000/%h", i, strobes, inst, exp_inst);
            end
            next_cycle();
            if (kind <= 1) begin
                exp_st = (kind == 1) ? 5'b00011 : 5'b00010;
                for (int c = 0; c < 3; c++) begin
                    run = 1'($urandom_range(0, 1));
                    #2;
                    checks++;
                    if (strobes !== exp_st || pc !== exp_pc || inst !== exp_inst) begin
                        failures++;
                        $display("FAIL rnd_halt i=%0d got=%b/%h exp=%b/%h", i, strobes, pc, exp_st, exp_pc);
                    end
                    next_cycle();
                end
                dec_illegal = 1'b0;
                return;
            end
            run = ($urandom_range(0, 2) != 0);
            #2;
            checks++;
            if (strobes !== 5'b01000) begin
                failures++;
                $display("FAIL rnd_exec i=%0d got=%b exp=01000", i, strobes);
            end
            next_cycle();
            exp_st = {2'b00, wen, 2'b00};
            #2;
            checks++;
            if (strobes !== exp_st || pc !== exp_pc) begin
                failures++;
                $display("FAIL rnd_wb i=%0d got=%b/%h exp=%b/%h", i, strobes, pc, exp_st, exp_pc);
            end
            in_fetch = run;
            next_cycle();
            exp_pc = exp_pc + 32'd4;
            run    = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ebreak();
        test_illegal();
        test_timeout();
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            test_random_program(40);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
